wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/async_fifo_pkg.sv | 27 ++
 rtl/gray2bin.sv | 14 +
 rtl/wptr_full_ctrl.sv | 80 ++++++++
 tb/tb_wptr_full_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer handlers (write and read side):
// depth derivation, binary->Gray conversion and the Gray full compare.
package async_fifo_pkg;

  // FIFO depth for a given address width.
  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // Binary to reflected Gray; callers truncate the result to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Full when the local Gray pointer equals the remote one with its two MSBs
  // inverted, i.e. the binary pointers differ by exactly DEPTH. n = ptr width.
  function automatic logic ptr_full(input logic [31:0] wg,
                                    input logic [31:0] rg,
                                    input int          n);
    logic [31:0] mask;
    logic [31:0] tgt;
    mask = (32'd1 << n) - 32'd1;
    tgt  = rg ^ (32'd3 << (n - 2));
    return ((wg ^ tgt) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray to binary converter; each binary bit is the XOR of all
// Gray bits at and above it. Used for the synchronised remote pointer.
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full handler of an async FIFO. Keeps the binary and
// registered Gray write pointers, derives full against the synchronised read
// pointer, a registered fill level and a sticky overflow flag.
// Optional out_almost_full port/logic under macro WPTR_ALMOST_FULL_EN.
module wptr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ASIZE     = 3,
  parameter int AF_MARGIN = 1
) (
  input  logic             wrclk,
  input  logic             in_reset,
  input  logic             in_wr_en,
  input  logic             in_ovf_clr,
  input  logic [ASIZE:0]   sync_rptr_gray,
  output logic [ASIZE-1:0] wptr_binary_addr,
  output logic [ASIZE:0]   wptr_gray,
  output logic             wr_en_RAM,
  output logic             out_full,
  output logic [ASIZE:0]   out_level,
  output logic             out_overflow
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic             out_almost_full
`endif
);

  localparam int DEPTH = fifo_depth(ASIZE);
  localparam int PW    = ASIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] level_nxt;

  gray2bin #(.N(PW)) u_rptr_g2b (
    .gray (sync_rptr_gray),
    .bin  (rbin)
  );

  // Full is combinational so a read-pointer update frees a slot the same cycle.
  assign out_full         = ptr_full(32'(wgray), 32'(sync_rptr_gray), PW);
  assign wr_en_RAM        = in_wr_en && !out_full;
  assign wbin_nxt         = wbin + PW'(wr_en_RAM);
  assign level_nxt        = wbin - rbin;
  assign wptr_binary_addr = wbin[ASIZE-1:0];
  assign wptr_gray        = wgray;

  // Pointer pair, fill level and sticky overflow; reset beats writes and clear.
  always_ff @(posedge wrclk) begin
    if (in_reset) begin
      wbin         <= '0;
      wgray        <= '0;
      out_level    <= '0;
      out_overflow <= 1'b0;
    end else begin
      wbin      <= wbin_nxt;
      wgray     <= PW'(bin2gray(32'(wbin_nxt)));
      out_level <= level_nxt;
      if (in_wr_en && out_full)
        out_overflow <= 1'b1;
      else if (in_ovf_clr)
        out_overflow <= 1'b0;
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  // Almost-full tracks the same next level that feeds out_level.
  always_ff @(posedge wrclk) begin
    if (in_reset)
      out_almost_full <= 1'b0;
    else
      out_almost_full <= (level_nxt >= AF_THRESH);
  end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl (ASIZE=3, AF_MARGIN=2): vector table with hand
// expectations plus an arithmetic reference model; post-edge expectations
// are queued at drive time and popped after the clock edge.
module tb_wptr_full_ctrl;

  localparam int ASIZE = 3;
  localparam int AFM   = 2;
  localparam int D     = -1;

  logic             wrclk = 1'b0;
  logic             in_reset = 1'b0;
  logic             in_wr_en = 1'b0;
  logic             in_ovf_clr = 1'b0;
  logic [ASIZE:0]   sync_rptr_gray = '0;
  logic [ASIZE-1:0] wptr_binary_addr;
  logic [ASIZE:0]   wptr_gray;
  logic             wr_en_RAM;
  logic             out_full;
  logic [ASIZE:0]   out_level;
  logic             out_overflow;
`ifdef WPTR_ALMOST_FULL_EN
  logic             out_almost_full;
`endif

  wptr_full_ctrl #(.ASIZE(ASIZE), .AF_MARGIN(AFM)) dut (
    .wrclk            (wrclk),
    .in_reset         (in_reset),
    .in_wr_en         (in_wr_en),
    .in_ovf_clr       (in_ovf_clr),
    .sync_rptr_gray   (sync_rptr_gray),
    .wptr_binary_addr (wptr_binary_addr),
    .wptr_gray        (wptr_gray),
    .wr_en_RAM        (wr_en_RAM),
    .out_full         (out_full),
    .out_level        (out_level),
    .out_overflow     (out_overflow)
`ifdef WPTR_ALMOST_FULL_EN
    ,
    .out_almost_full  (out_almost_full)
`endif
  );

  always #5 wrclk = ~wrclk;

  typedef struct {
    bit rst; bit wr; bit clr; int rb;
    int e_full; int e_wen; int e_addr;
    int e_gray; int e_lvl; int e_ovf; int e_af;
  } vec_t;

  typedef struct {
    int t_gray; int t_lvl; int t_ovf; int t_af;
    int m_gray; int m_lvl; int m_ovf; int m_af;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    errors = 0;
  int    checks = 0;

  // reference model state
  int m_wbin = 0;
  int m_lvl  = 0;
  int m_ovf  = 0;
  int m_af   = 0;
  bit m_ok   = 0;

  function automatic int gray4(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit wr, input bit clr, input int rb,
                     input int ef, input int ew, input int ea,
                     input int eg, input int el, input int eo, input int eaf);
    vec_t v;
    v = '{rst, wr, clr, rb, ef, ew, ea, eg, el, eo, eaf};
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    post_t p;
    int    af_act;
    bit    m_full;
    int    lvl_n;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge wrclk);
    in_reset       = v.rst;
    in_wr_en       = v.wr;
    in_ovf_clr     = v.clr;
    sync_rptr_gray = 4'(gray4(v.rb));
    #1;
    // combinational checks before the edge
    m_full = ((m_wbin - v.rb) & 15) == 8;
    if (!v.rst) begin
      chk({tag, " full"},    int'(out_full),         v.e_full);
      chk({tag, " wen"},     int'(wr_en_RAM),        v.e_wen);
      chk({tag, " addr"},    int'(wptr_binary_addr), v.e_addr);
      if (m_ok) begin
        chk({tag, " m_full"}, int'(out_full),         int'(m_full));
        chk({tag, " m_wen"},  int'(wr_en_RAM),        int'(v.wr && !m_full));
        chk({tag, " m_addr"}, int'(wptr_binary_addr), m_wbin & 7);
      end
    end
    // model step
    if (v.rst) begin
      m_wbin = 0; m_lvl = 0; m_ovf = 0; m_af = 0; m_ok = 1;
    end else begin
      lvl_n = (m_wbin - v.rb) & 15;
      m_lvl = lvl_n;
      m_af  = (lvl_n >= 8 - AFM) ? 1 : 0;
      if (v.wr && m_full) m_ovf = 1;
      else if (v.clr)     m_ovf = 0;
      if (v.wr && !m_full) m_wbin = (m_wbin + 1) & 15;
    end
    p = '{v.e_gray, v.e_lvl, v.e_ovf, v.e_af,
          gray4(m_wbin), m_lvl, m_ovf, m_af};
    sb.push_back(p);
    @(posedge wrclk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      return;
    end
    p = sb.pop_front();
`ifdef WPTR_ALMOST_FULL_EN
    af_act = int'(out_almost_full);
`else
    af_act = 0;
    p.t_af = D;
    p.m_af = D;
`endif
    chk({tag, " gray"},   int'(wptr_gray),    p.t_gray);
    chk({tag, " lvl"},    int'(out_level),    p.t_lvl);
    chk({tag, " ovf"},    int'(out_overflow), p.t_ovf);
    chk({tag, " af"},     af_act,             p.t_af);
    chk({tag, " m_gray"}, int'(wptr_gray),    p.m_gray);
    chk({tag, " m_lvl"},  int'(out_level),    p.m_lvl);
    chk({tag, " m_ovf"},  int'(out_overflow), p.m_ovf);
    chk({tag, " m_af"},   af_act,             p.m_af);
  endtask

  initial begin
    //   rst wr clr rb   full wen addr  gray lvl ovf af
    // reset held with writes requested
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, D, D, D, 0, 0, 0, 0);
    // fill from empty: 8 accepted writes, then two dropped
    add(0, 1, 0, 0,  0, 1, 0,  1, 0, 0, 0);
    for (int i = 2; i <= 6; i++) add(0, 1, 0, 0, 0, 1, i - 1, D, D, 0, D);
    add(0, 1, 0, 0,  0, 1, 6,  4, 6, 0, 1);
    add(0, 1, 0, 0,  0, 1, 7, 12, 7, 0, 1);
    add(0, 1, 0, 0,  1, 0, 0, 12, 8, 1, 1);
    add(0, 1, 0, 0,  1, 0, 0, 12, 8, 1, 1);
    // read of 8 frees space same cycle; next write wraps to address 0
    add(0, 0, 0, 8,  0, 0, 0, 12, 0, 1, 0);
    add(0, 1, 0, 8,  0, 1, 0, 13, 0, 1, 0);
    // full again; clear with a dropped write loses, clear alone wins
    add(0, 1, 1, 1,  1, 0, 1, 13, 8, 1, 1);
    add(0, 0, 1, 1,  1, 0, 1, 13, 8, 0, 1);
    // reset, then 6 writes and a level / almost-full readout
    add(1, 0, 0, 0,  D, D, D,  0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, 1, i, gray4(i + 1), i, 0, D);
    add(0, 0, 0, 0,  0, 0, 6,  5, 6, 0, 1);
    add(0, 0, 0, 2,  0, 0, 6,  5, 4, 0, 0);
    // 5 writes then reset mid-burst, resume from address 0
    for (int i = 0; i < 5; i++) add(0, 1, 0, 6, 0, 1, (6 + i) & 7, D, D, 0, D);
    add(1, 1, 1, 6,  D, D, D,  0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0,  0, 1, 1,  3, 1, 0, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
